// File: rtl/frac_clk_div_prog.sv
// Runtime-programmable fractional clock divider: cfg_dst output periods per cfg_src clk cycles.
// A restoring divider turns a new ratio into Q/R and commits it at a period boundary.
module frac_clk_div_prog #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic [CNT_W-1:0] cfg_src,
  input  logic [CNT_W-1:0] cfg_dst,
  input  logic             cfg_mode,
  input  logic             cfg_load,
  output logic             cfg_busy,
  output logic             cfg_ack,
  output logic             cfg_err,
  output logic             clk_frac
);

  localparam int IW = $clog2(CNT_W + 1);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
  localparam logic [CNT_W:0]   ONE_W = (CNT_W + 1)'(1);

  typedef enum logic [1:0] {IDLE, DIV, PEND} state_t;

  state_t           state;
  logic             cfg_valid;
  logic             run;
  logic [IW-1:0]    div_cnt;
  logic [CNT_W-1:0] div_q, div_r, new_d;
  logic             new_mode;
  logic [CNT_W-1:0] act_q, act_r, act_d;
  logic             act_mode;
  logic [CNT_W-1:0] cnt, len;
  logic [CNT_W:0]   acc;

  logic             running, period_end, start, commit, ge;
  logic [CNT_W-1:0] use_q, use_r, use_d, len_nx, r_nx;
  logic [CNT_W:0]   acc_base, t, acc_nx, trial;

  // ceil(len/2) high phase in duty mode; single-cycle strobe at cnt==0 otherwise
  function automatic logic out_level(input logic [CNT_W-1:0] c, input logic [CNT_W-1:0] l,
                                     input logic m);
    logic [CNT_W:0] half;
    half = ({1'b0, l} + ONE_W) >> 1;
    return m ? ({1'b0, c} < half) : (c == '0);
  endfunction

  always_comb begin
    running    = en & cfg_valid;
    period_end = (cnt == len - ONE);
    start      = running & (~run | period_end);
    commit     = (state == PEND) & (~running | start);
    // A committing period takes the fresh quotient/remainder with a cleared accumulator
    use_q    = commit ? div_q : act_q;
    use_r    = commit ? div_r : act_r;
    use_d    = commit ? new_d : act_d;
    acc_base = (run & ~commit) ? acc : '0;
    t        = acc_base + {1'b0, use_r};
    if (t >= {1'b0, use_d}) begin
      len_nx = use_q + ONE;
      acc_nx = t - {1'b0, use_d};
    end else begin
      len_nx = use_q;
      acc_nx = t;
    end
    // Restoring division step: shift next dividend bit into the partial remainder
    trial = {div_r, div_q[CNT_W-1]};
    ge    = trial[CNT_W] | (trial[CNT_W-1:0] >= new_d);
    r_nx  = ge ? (trial[CNT_W-1:0] - new_d) : trial[CNT_W-1:0];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      cfg_valid <= 1'b0;
      cfg_busy  <= 1'b0;
      cfg_ack   <= 1'b0;
      cfg_err   <= 1'b0;
      div_cnt   <= '0;
      div_q     <= '0;
      div_r     <= '0;
      new_d     <= '0;
      new_mode  <= 1'b0;
      act_q     <= '0;
      act_r     <= '0;
      act_d     <= '0;
      act_mode  <= 1'b0;
      run       <= 1'b0;
      cnt       <= '0;
      len       <= '0;
      acc       <= '0;
      clk_frac  <= 1'b0;
    end else begin
      cfg_ack <= 1'b0;
      cfg_err <= 1'b0;
      case (state)
        IDLE: begin
          if (cfg_load) begin
            if (cfg_dst == '0 || cfg_src < cfg_dst) begin
              cfg_err <= 1'b1;
            end else begin
              div_q    <= cfg_src;
              div_r    <= '0;
              new_d    <= cfg_dst;
              new_mode <= cfg_mode;
              div_cnt  <= '0;
              cfg_busy <= 1'b1;
              state    <= DIV;
            end
          end
        end
        DIV: begin
          div_q   <= {div_q[CNT_W-2:0], ge};
          div_r   <= r_nx;
          div_cnt <= div_cnt + IW'(1);
          if (div_cnt == IW'(CNT_W - 1)) state <= PEND;
        end
        PEND: begin
          if (commit) begin
            act_q     <= div_q;
            act_r     <= div_r;
            act_d     <= new_d;
            act_mode  <= new_mode;
            cfg_valid <= 1'b1;
            cfg_ack   <= 1'b1;
            cfg_busy  <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      run <= running;
      if (start) begin
        cnt <= '0;
        len <= len_nx;
        acc <= acc_nx;
      end else if (running) begin
        cnt <= cnt + ONE;
      end else begin
        cnt <= '0;
        acc <= '0;
      end
      clk_frac <= (run & en) ? out_level(cnt, len, act_mode) : 1'b0;
    end
  end

endmodule

// File: tb/tb_frac_clk_div_prog.sv
// Bench for frac_clk_div_prog: output compared cycle by cycle against a frame-arithmetic model
// where period k spans cycles floor(k*S/D) .. floor((k+1)*S/D)-1.
module tb_frac_clk_div_prog;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         en = 1'b0;
  logic [W-1:0] cfg_src = '0;
  logic [W-1:0] cfg_dst = '0;
  logic         cfg_mode = 1'b0;
  logic         cfg_load = 1'b0;
  logic         cfg_busy, cfg_ack, cfg_err, clk_frac;

  frac_clk_div_prog #(.CNT_W(W)) dut (
    .clk(clk), .rstn(rstn), .en(en), .cfg_src(cfg_src), .cfg_dst(cfg_dst),
    .cfg_mode(cfg_mode), .cfg_load(cfg_load), .cfg_busy(cfg_busy), .cfg_ack(cfg_ack),
    .cfg_err(cfg_err), .clk_frac(clk_frac)
  );

  always #5 clk = ~clk;

  int vec = 0;
  int miss = 0;
  int tc = 0;
  int cur_s, cur_d, cur_m, o_cur;
  int prv_s, prv_d, prv_m, o_prv;
  bit prv_ok = 0;
  bit active = 0;
  logic exp_clk;

  function automatic longint bnd(longint s, longint d, longint k);
    return (k * s) / d;
  endfunction

  // Expected level for cycle c (c=0 is the first cycle of period 0) of an S/D frame
  function automatic logic model(int s, int d, int m, longint c);
    longint k, len, pos;
    k = (c * d) / s;
    while (bnd(s, d, k + 1) <= c) k++;
    len = bnd(s, d, k + 1) - bnd(s, d, k);
    pos = c - bnd(s, d, k);
    return m != 0 ? (pos < (len + 1) / 2) : (pos == 0);
  endfunction

  // Output after edge tc reflects the divider position during cycle tc-1
  function automatic logic expect_clk();
    longint c;
    if (!active) return 1'b0;
    c = tc - 1;
    if (c >= o_cur) return model(cur_s, cur_d, cur_m, c - o_cur);
    if (prv_ok && c >= o_prv) return model(prv_s, prv_d, prv_m, c - o_prv);
    return 1'b0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    tc++;
    exp_clk = expect_clk();
  endtask

  task automatic program_idle(input int s, input int d, input int m, output int lat,
                              output logic busy0);
    cfg_src = s[W-1:0]; cfg_dst = d[W-1:0]; cfg_mode = m[0]; cfg_load = 1'b1;
    step();
    cfg_load = 1'b0;
    busy0 = cfg_busy;
    lat = 0;
    while (cfg_ack !== 1'b1 && lat < 200) begin
      step();
      lat++;
    end
  endtask

  task automatic start_run(input int s, input int d, input int m);
    cur_s = s; cur_d = d; cur_m = m;
    o_cur = tc + 1;
    prv_ok = 0;
    active = 1;
    en = 1'b1;
  endtask

  task automatic stop_run();
    en = 1'b0;
    step();
    active = 0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    step(); step();
    vec++; if (clk_frac !== 1'b0) begin miss++; $display("FAIL reset_clk_frac got %b want 0", clk_frac); end
    vec++; if (cfg_busy !== 1'b0) begin miss++; $display("FAIL reset_busy got %b want 0", cfg_busy); end
    vec++; if (cfg_ack !== 1'b0) begin miss++; $display("FAIL reset_ack got %b want 0", cfg_ack); end
    vec++; if (cfg_err !== 1'b0) begin miss++; $display("FAIL reset_err got %b want 0", cfg_err); end
    rstn = 1'b1;
    en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      vec++; if (clk_frac !== 1'b0) begin miss++; $display("FAIL noconfig_clk got %b want 0", clk_frac); end
    end
    en = 1'b0;
    step();
  endtask

  task automatic test_idle_load();
    int lat;
    logic b0;
    program_idle(76, 10, 0, lat, b0);
    vec++; if (b0 !== 1'b1) begin miss++; $display("FAIL idle_busy got %b want 1", b0); end
    vec++; if (lat != W + 1) begin miss++; $display("FAIL idle_ack_latency got %0d want %0d", lat, W + 1); end
    step();
    vec++; if (cfg_ack !== 1'b0 || cfg_busy !== 1'b0) begin
      miss++; $display("FAIL idle_after_ack got ack=%b busy=%b want 0 0", cfg_ack, cfg_busy);
    end
  endtask

  task automatic test_mode0_76_10();
    int pulses = 0;
    start_run(76, 10, 0);
    for (int i = 0; i < 3 * 76 + 1; i++) begin
      step();
      if (clk_frac === 1'b1) pulses++;
      vec++; if (clk_frac !== exp_clk) begin
        miss++; $display("FAIL m0_76_10 tick %0d got %b want %b", i, clk_frac, exp_clk);
      end
    end
    vec++; if (pulses != 30) begin miss++; $display("FAIL m0_pulse_count got %0d want 30", pulses); end
    stop_run();
    for (int i = 0; i < 3; i++) begin
      step();
      vec++; if (clk_frac !== 1'b0) begin miss++; $display("FAIL en_fall got %b want 0", clk_frac); end
    end
  endtask

  task automatic test_switch();
    int ld_tc, acks, last_p, nrun;
    start_run(76, 10, 0);
    nrun = $urandom_range(20, 60);
    for (int i = 0; i < nrun; i++) begin
      step();
      vec++; if (clk_frac !== exp_clk) begin miss++; $display("FAIL sw_pre got %b want %b", clk_frac, exp_clk); end
    end
    cfg_src = 16'd9; cfg_dst = 16'd4; cfg_mode = 1'b0; cfg_load = 1'b1;
    step();
    cfg_load = 1'b0;
    ld_tc = tc;
    vec++; if (cfg_busy !== 1'b1) begin miss++; $display("FAIL sw_busy got %b want 1", cfg_busy); end
    acks = 0;
    last_p = -1;
    for (int i = 0; i < 80; i++) begin
      if (i == 3) begin cfg_src = 16'd5; cfg_dst = 16'd0; cfg_load = 1'b1; end
      step();
      if (i == 3) cfg_load = 1'b0;
      if (i == 4) begin
        vec++; if (cfg_err !== 1'b0) begin miss++; $display("FAIL busy_load_err got %b want 0", cfg_err); end
      end
      vec++; if (clk_frac !== exp_clk) begin miss++; $display("FAIL sw_run tick %0d got %b want %b", i, clk_frac, exp_clk); end
      if (clk_frac === 1'b1) begin
        if (last_p >= 0) begin
          vec++; if (tc - last_p < 2 || tc - last_p > 8) begin
            miss++; $display("FAIL sw_spacing got %0d want 2..8", tc - last_p);
          end
        end
        last_p = tc;
      end
      if (cfg_ack === 1'b1) begin
        acks++;
        if (acks == 1) begin
          vec++; if (tc - ld_tc < W + 1 || tc - ld_tc > W + 1 + 8) begin
            miss++; $display("FAIL sw_ack_latency got %0d want %0d..%0d", tc - ld_tc, W + 1, W + 9);
          end
          vec++; if (model(cur_s, cur_d, 0, tc - o_cur) !== 1'b1) begin
            miss++; $display("FAIL sw_boundary got offset %0d want old period start", tc - o_cur);
          end
          prv_s = cur_s; prv_d = cur_d; prv_m = cur_m; o_prv = o_cur; prv_ok = 1;
          cur_s = 9; cur_d = 4; cur_m = 0; o_cur = tc;
        end
      end
    end
    vec++; if (acks != 1) begin miss++; $display("FAIL sw_ack_count got %0d want 1", acks); end
  endtask

  task automatic test_reject();
    int acks = 0;
    for (int r = 0; r < 2; r++) begin
      cfg_src = (r == 0) ? 16'd5 : 16'd3;
      cfg_dst = (r == 0) ? 16'd0 : 16'd5;
      cfg_load = 1'b1;
      step();
      cfg_load = 1'b0;
      vec++; if (cfg_err !== 1'b1 || cfg_busy !== 1'b0) begin
        miss++; $display("FAIL rej%0d got err=%b busy=%b want 1 0", r, cfg_err, cfg_busy);
      end
      vec++; if (clk_frac !== exp_clk) begin miss++; $display("FAIL rej_clk got %b want %b", clk_frac, exp_clk); end
      step();
      vec++; if (cfg_err !== 1'b0) begin miss++; $display("FAIL rej%0d_pulse got %b want 0", r, cfg_err); end
    end
    for (int i = 0; i < W + 8; i++) begin
      step();
      if (cfg_ack === 1'b1) acks++;
      vec++; if (clk_frac !== exp_clk) begin miss++; $display("FAIL rej_keep got %b want %b", clk_frac, exp_clk); end
    end
    vec++; if (acks != 0) begin miss++; $display("FAIL rej_ack got %0d want 0", acks); end
    stop_run();
  endtask

  task automatic test_modes();
    int cs[8], cd[8], cm[8];
    int lat, n;
    logic b0;
    cs[0] = 5;     cd[0] = 1;     cm[0] = 1;
    cs[1] = 7;     cd[1] = 7;     cm[1] = 1;
    cs[2] = 7;     cd[2] = 7;     cm[2] = 0;
    cs[3] = 65535; cd[3] = 65534; cm[3] = 0;
    cs[4] = 65535; cd[4] = 1;     cm[4] = 0;
    for (int i = 5; i < 8; i++) begin
      cd[i] = $urandom_range(1, 12);
      cs[i] = $urandom_range(cd[i], 9 * cd[i]);
      cm[i] = $urandom_range(0, 1);
    end
    for (int i = 0; i < 8; i++) begin
      program_idle(cs[i], cd[i], cm[i], lat, b0);
      vec++; if (lat != W + 1) begin miss++; $display("FAIL mode_cfg%0d latency got %0d want %0d", i, lat, W + 1); end
      start_run(cs[i], cd[i], cm[i]);
      n = (2 * cs[i] + 4 < 300) ? 2 * cs[i] + 4 : 300;
      for (int j = 0; j < n; j++) begin
        step();
        vec++; if (clk_frac !== exp_clk) begin
          miss++; $display("FAIL mode S=%0d D=%0d m=%0d tick %0d got %b want %b", cs[i], cd[i], cm[i], j, clk_frac, exp_clk);
        end
      end
      stop_run();
      step();
    end
  endtask

  task automatic test_reset_mid_pend();
    int lat, acks;
    logic b0;
    program_idle(200, 1, 1, lat, b0);
    start_run(200, 1, 1);
    for (int i = 0; i < 5; i++) step();
    cfg_src = 16'd10; cfg_dst = 16'd3; cfg_mode = 1'b0; cfg_load = 1'b1;
    step();
    cfg_load = 1'b0;
    for (int i = 0; i < W + 4; i++) begin
      step();
      vec++; if (clk_frac !== exp_clk) begin miss++; $display("FAIL pend_clk got %b want %b", clk_frac, exp_clk); end
    end
    vec++; if (cfg_busy !== 1'b1) begin miss++; $display("FAIL pend_busy got %b want 1", cfg_busy); end
    #2 rstn = 1'b0;
    #1;
    vec++; if ({cfg_busy, cfg_ack, cfg_err, clk_frac} !== 4'b0) begin
      miss++; $display("FAIL rst_mid_pend got %b want 0000", {cfg_busy, cfg_ack, cfg_err, clk_frac});
    end
    step();
    rstn = 1'b1;
    active = 0;
    acks = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (cfg_ack === 1'b1) acks++;
      vec++; if (clk_frac !== 1'b0) begin miss++; $display("FAIL post_rst_clk got %b want 0", clk_frac); end
    end
    vec++; if (acks != 0) begin miss++; $display("FAIL post_rst_ack got %0d want 0", acks); end
    en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_idle_load();
    test_mode0_76_10();
    test_switch();
    test_reject();
    test_modes();
    test_reset_mid_pend();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule

// File: doc/frac_clk_div_prog.md
# frac_clk_div_prog

Runtime-programmable fractional clock divider. It emits exactly `cfg_dst` output periods for every `cfg_src` input clock cycles, using any integer ratio up to `CNT_W` bits. It adds two things over fixed-ratio dividers:
- a pulse or near-50% duty output mode;
- a sequential divider that turns the ratio into quotient and remainder, with the new ratio committed glitch-free at a period boundary.

It sits in the clock-generation area and feeds strobes or derived clocks to downstream logic.

## Interface
- `CNT_W`, default 16: width of the ratio operands, counters and quotient/remainder.
- `clk`  input  1  source clock.
- `rstn`  input  1  reset, asynchronous, active-low.
- `en`  input  1  run enable, level.
- `cfg_src`  input  CNT_W  source cycles per frame, S.
- `cfg_dst`  input  CNT_W  output periods per frame, D.
- `cfg_mode`  input  1  0 = one-cycle pulse per period; 1 = near-50% duty. Sampled together with `cfg_src`/`cfg_dst`.
- `cfg_load`  input  1  single-cycle request to load a new configuration.
- `cfg_busy`  output  1  high from an accepted load until its commit.
- `cfg_ack`  output  1  one-cycle pulse in the commit cycle.
- `cfg_err`  output  1  one-cycle pulse, the cycle after a rejected load.
- `clk_frac`  output  1  divided output, registered.

## Operation
- **FSM states:**
  - IDLE: no valid config, or idle.
  - DIV: divider iterating.
  - PEND: result waiting for a period boundary.
  - Return to IDLE or stay running after commit; a `run` flag is kept separately.
- **Load check:** `cfg_load` is acted on only when `cfg_busy`=0. It is ignored with no error and no ack while busy.
- **Rejected loads:** D==0 or S<D → `cfg_err` pulse. Old config, state and output are unchanged.
- **Accepted loads:** latch S, D and mode, then enter DIV. A restoring divider runs for exactly CNT_W cycles and produces Q=S/D (Q≥1) and R=S%D.
- **Commit after DIV:**
  - Not running (`en`=0 or no valid config): commit in the cycle after DIV ends.
  - Running: enter PEND and commit at the first period-start edge. The new period uses the new Q/R/mode with acc cleared.
  - Commit pulses `cfg_ack`, drops `cfg_busy`, and sets `cfg_valid`.
- **Run:** active when `en`=1 and `cfg_valid`=1.
  - A period counter `cnt` runs 0..len-1.
  - At each period start: t = acc+R. If t≥D then len=Q+1 and acc←t−D; otherwise len=Q and acc←t.
  - acc is CNT_W+1 bits wide. t<2D, so it never overflows.
  - Over any D consecutive periods the lengths sum to exactly S.
- **Output:**
  - Mode 0: high in the cycle when cnt==0 of each period.
  - Mode 1: high while cnt < ceil(len/2).
  - With len==1 the output is constant 1 in both modes.
- **`en` falling:** cnt and acc clear immediately and `clk_frac` goes 0 on the next edge. Config and any DIV/PEND activity are retained. PEND with `en`=0 commits on the next cycle.
- **`en` rising:** period 0 starts on the first edge that samples `en`=1, with acc=0.
- **Reset mid-operation:** all state clears and `cfg_valid`=0. A new load is required.

## Timing
- **Reset values:** `clk_frac`=0, `cfg_busy`=0, `cfg_ack`=0, `cfg_err`=0, `cfg_valid`=0, cnt=0, acc=0, FSM=IDLE.
- **`cfg_err`:** asserted the cycle after the `cfg_load` edge.
- **`cfg_busy`:** asserted the cycle after an accepted load.
- **Idle load to commit:** `cfg_ack` is CNT_W+1 cycles after the `cfg_load` edge.
- **Running load to commit:** CNT_W+1 cycles plus the wait for the next period start. Worst case adds Q+1 cycles.
- **`clk_frac` latency:** one register stage; it reflects the cnt value of the previous cycle. The first high occurs one cycle after the start edge.
- **Commit at a period boundary:** the period starting on that edge already uses the new len and mode. No truncated or merged period appears at the transition.
- **`cfg_load` in the same cycle as `en` change:** both take effect. The load is checked against the busy state before that edge.

## Test plan
- S=76, D=10, mode 0, `en`=1 → pulse spacings repeat 7,8,7,8,8,7,8,7,8,8; 10 pulses per 76 cycles over 3 frames.
- While running 76/10, load S=9, D=4 → `cfg_ack` at a period start, then spacings 2,2,2,3 repeat; no spacing <2 or >8 at the switch.
- Load D=0, then S=3/D=5 → `cfg_err` pulses twice; the output keeps the previous ratio; no `cfg_ack`.
- S=5, D=1, mode 1 → 3 cycles high, 2 low. S=D=7 → `clk_frac` constant 1. `cfg_load` during DIV → ignored, single `cfg_ack`.
- Assert `rstn` low mid-PEND → all outputs 0. After release, `en`=1 with no load → `clk_frac` stays 0.
- CNT_W=16, S=65535, D=65534 → Q=1, R=1; one len-2 period per 65534 periods; no acc overflow.
